// File: rtl/capture_frame_filter.sv
// capture_frame_filter: forwards only well-formed two-beat capture frames (header beat + payload beat).
// Defining CAPTURE_FILTER_STATS_EN builds the saturating frames_passed/frames_dropped counters.
module capture_frame_filter #(
  parameter int          DATA_WIDTH     = 512,
  parameter int          KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter logic [15:0] ETHERTYPE      = 16'h88B5,
  parameter int          LAST_MIN_BYTES = 42
) (
  input  logic                  clk_stream,
  input  logic                  resetn_stream,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  filter_en,
  input  logic                  clear_stats,
  output logic [31:0]           frames_passed,
  output logic [31:0]           frames_dropped
);

  typedef enum logic [2:0] {IDLE, HOLD, EMIT0, EMIT1, DRAIN} state_t;

  state_t                state, state_nxt;
  logic                  s_fire, good0, good1;
  logic                  ld_hold, ld_tail, ld_out0, ld_out1, clr_out;
  logic                  inc_pass, inc_drop;
  logic [DATA_WIDTH-1:0] hold_data_p0, tail_data_p0;
  logic [KEEP_WIDTH-1:0] tail_keep_p0;

  assign s_axis_tready = (state == IDLE) || (state == HOLD) || (state == DRAIN);
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  // EtherType sits in bytes 12 (high) and 13 (low) of the header beat.
  assign good0 = filter_en
              && ({s_axis_tdata[103:96], s_axis_tdata[111:104]} == ETHERTYPE)
              && (&s_axis_tkeep)
              && !s_axis_tlast;
  assign good1 = s_axis_tlast && (&s_axis_tkeep[LAST_MIN_BYTES-1:0]);

  always_ff @(posedge clk_stream or negedge resetn_stream) begin
    if (!resetn_stream) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_hold   = 1'b0;
    ld_tail   = 1'b0;
    ld_out0   = 1'b0;
    ld_out1   = 1'b0;
    clr_out   = 1'b0;
    inc_pass  = 1'b0;
    inc_drop  = 1'b0;
    case (state)
      IDLE: if (s_fire) begin
        if (good0) begin
          ld_hold   = 1'b1;
          state_nxt = HOLD;
        end else if (s_axis_tlast) begin
          inc_drop  = 1'b1;
        end else begin
          state_nxt = DRAIN;
        end
      end
      HOLD: if (s_fire) begin
        if (good1) begin
          ld_tail   = 1'b1;
          ld_out0   = 1'b1;
          state_nxt = EMIT0;
        end else if (s_axis_tlast) begin
          inc_drop  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      EMIT0: if (m_axis_tready) begin
        ld_out1   = 1'b1;
        state_nxt = EMIT1;
      end
      EMIT1: if (m_axis_tready) begin
        clr_out   = 1'b1;
        inc_pass  = 1'b1;
        state_nxt = IDLE;
      end
      DRAIN: if (s_fire && s_axis_tlast) begin
        inc_drop  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture header and payload beats
  always_ff @(posedge clk_stream) begin
    if (ld_hold) hold_data_p0 <= s_axis_tdata;
    if (ld_tail) begin
      tail_data_p0 <= s_axis_tdata;
      tail_keep_p0 <= s_axis_tkeep;
    end
  end

  // Stage p1: registered output beat, held while downstream stalls
  always_ff @(posedge clk_stream or negedge resetn_stream) begin
    if (!resetn_stream) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
    end else if (ld_out0) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= hold_data_p0;
      m_axis_tkeep  <= '1;
    end else if (ld_out1) begin
      m_axis_tlast  <= 1'b1;
      m_axis_tdata  <= tail_data_p0;
      m_axis_tkeep  <= tail_keep_p0;
    end else if (clr_out) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

`ifdef CAPTURE_FILTER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] passed_q, dropped_q;

  always_ff @(posedge clk_stream or negedge resetn_stream) begin
    if (!resetn_stream) begin
      passed_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (clear_stats)   passed_q  <= '0;
      else if (inc_pass) passed_q  <= sat_inc(passed_q);
      if (clear_stats)   dropped_q <= '0;
      else if (inc_drop) dropped_q <= sat_inc(dropped_q);
    end
  end

  assign frames_passed  = passed_q;
  assign frames_dropped = dropped_q;
`else
  logic unused_stats;
  assign unused_stats   = clear_stats ^ inc_pass ^ inc_drop;
  assign frames_passed  = '0;
  assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_capture_frame_filter.sv
// Bench for capture_frame_filter: frame-level model predicts forwarded beats and counters;
// a negedge monitor compares every presented output beat against the expected queue.
module tb_capture_frame_filter;

`ifdef CAPTURE_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk_stream = 1'b0;
  logic         resetn_stream;
  logic         s_axis_tvalid;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic         m_axis_tvalid;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         filter_en;
  logic         clear_stats;
  logic [31:0]  frames_passed;
  logic [31:0]  frames_dropped;

  capture_frame_filter dut (
    .clk_stream    (clk_stream),
    .resetn_stream (resetn_stream),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .filter_en     (filter_en),
    .clear_stats   (clear_stats),
    .frames_passed (frames_passed),
    .frames_dropped(frames_dropped)
  );

  always #5 clk_stream = ~clk_stream;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    vectors       = 0;
  int    miscompares   = 0;
  int    model_passed  = 0;
  int    model_dropped = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int v);
    return STATS ? v : 0;
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_stream);
    #1;
  endtask

  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                            output int waits);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    waits = 0;
    while (!s_axis_tready && waits < 200) begin
      step(1);
      waits++;
    end
    if (!s_axis_tready) check("s_tready_timeout", 1'b0, 1'b1);
    step(1);
    s_axis_tvalid = 1'b0;
  endtask

  // Frame-level model: forwarded iff exactly two beats, filter enabled at frame start,
  // EtherType matches, header keep full and at least 42 low payload bytes valid.
  task automatic send_frame(input int nbeats, input logic [15:0] etype, input logic [63:0] keep0,
                            input logic [63:0] keepl, input logic en, input logic en_mid,
                            output int waits_total);
    beat_t        b[$];
    beat_t        cur;
    int           w;
    logic         pass;
    waits_total = 0;
    filter_en = en;
    for (int i = 0; i < nbeats; i++) begin
      cur.data = rand_data();
      if (i == 0) begin
        cur.data[103:96]  = etype[15:8];
        cur.data[111:104] = etype[7:0];
      end
      cur.keep = (i == 0) ? keep0 : ((i == nbeats - 1) ? keepl : 64'hFFFF_FFFF_FFFF_FFFF);
      cur.last = (i == nbeats - 1);
      b.push_back(cur);
      drive_beat(cur.data, cur.keep, cur.last, w);
      waits_total += w;
      if (i == 0) filter_en = en_mid;
    end
    pass = (nbeats == 2) && en && (etype == 16'h88B5) && (&keep0) && (&keepl[41:0]);
    if (pass) begin
      exp_q.push_back(b[0]);
      exp_q.push_back(b[1]);
      model_passed++;
    end else begin
      model_dropped++;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_passed"},  frames_passed,  exp_cnt(model_passed));
    check({tag, "_dropped"}, frames_dropped, exp_cnt(model_dropped));
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    step(1);
    clear_stats = 1'b0;
    model_passed  = 0;
    model_dropped = 0;
  endtask

  always @(negedge clk_stream) begin
    if (resetn_stream && m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_m_tvalid", m_axis_tvalid, 1'b0);
      end else begin
        check("m_tdata", m_axis_tdata, exp_q[0].data);
        check("m_tkeep", m_axis_tkeep, exp_q[0].keep);
        check("m_tlast", m_axis_tlast, exp_q[0].last);
        if (m_axis_tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] FULL  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN42 = 64'h3FF_FFFF_FFFF;

  initial begin
    int w;
    resetn_stream = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    filter_en     = 1'b1;
    clear_stats   = 1'b0;

    #2;
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tlast",  m_axis_tlast,  1'b0);
    check("rst_m_tdata",  m_axis_tdata,  '0);
    check("rst_m_tkeep",  m_axis_tkeep,  '0);
    check("rst_s_tready", s_axis_tready, 1'b1);
    check("rst_passed",   frames_passed, 32'd0);
    check("rst_dropped",  frames_dropped, 32'd0);
    step(1);
    resetn_stream = 1'b1;
    step(1);

    // T1: good frame, 42-byte payload keep
    send_frame(2, 16'h88B5, FULL, MIN42, 1'b1, 1'b1, w);
    check("t1_latency_vld", m_axis_tvalid, 1'b1);
    check("t1_beat0_last",  m_axis_tlast,  1'b0);
    check("t1_sready_emit", s_axis_tready, 1'b0);
    step(1);
    check("t1_beat1_vld",   m_axis_tvalid, 1'b1);
    check("t1_beat1_last",  m_axis_tlast,  1'b1);
    step(3);
    check("t1_idle_vld",    m_axis_tvalid, 1'b0);
    check_counts("t1");
    check("t1_passed_lit",  frames_passed, exp_cnt(1));

    // T2: wrong EtherType, never stalls input
    send_frame(2, 16'h0800, FULL, FULL, 1'b1, 1'b1, w);
    check("t2_no_wait",     w, 0);
    check("t2_sready",      s_axis_tready, 1'b1);
    step(3);
    check_counts("t2");
    check("t2_dropped_lit", frames_dropped, exp_cnt(1));

    // T3: 1-beat, 3-beat, then good frame after a counter clear
    pulse_clear();
    check_counts("t3_clr");
    send_frame(1, 16'h88B5, FULL, FULL, 1'b1, 1'b1, w);
    send_frame(3, 16'h88B5, FULL, FULL, 1'b1, 1'b1, w);
    send_frame(2, 16'h88B5, FULL, FULL, 1'b1, 1'b1, w);
    step(4);
    check_counts("t3");
    check("t3_passed_lit",  frames_passed,  exp_cnt(1));
    check("t3_dropped_lit", frames_dropped, exp_cnt(2));

    // Boundary frames
    send_frame(2, 16'h88B5, 64'hFFFF_FFFF_FFFF_FFFE, FULL, 1'b1, 1'b1, w);
    send_frame(2, 16'h88B5, FULL, 64'h1FF_FFFF_FFFF, 1'b1, 1'b1, w);
    send_frame(2, 16'h88B5, FULL, FULL, 1'b0, 1'b0, w);
    send_frame(2, 16'h88B5, FULL, MIN42, 1'b1, 1'b0, w);
    send_frame(2, 16'hB588, FULL, FULL, 1'b1, 1'b1, w);
    send_frame(4, 16'h88B5, FULL, FULL, 1'b1, 1'b1, w);
    filter_en = 1'b1;
    step(4);
    check_counts("bnd");
    check("bnd_passed_lit",  frames_passed,  exp_cnt(2));
    check("bnd_dropped_lit", frames_dropped, exp_cnt(7));

    // T4: downstream stall of 5 cycles
    m_axis_tready = 1'b0;
    send_frame(2, 16'h88B5, FULL, MIN42, 1'b1, 1'b1, w);
    for (int k = 0; k < 5; k++) begin
      check("t4_stall_sready", s_axis_tready, 1'b0);
      check("t4_stall_vld",    m_axis_tvalid, 1'b1);
      check("t4_stall_last",   m_axis_tlast,  1'b0);
      step(1);
    end
    m_axis_tready = 1'b1;
    step(1);
    check("t4_emit1_sready", s_axis_tready, 1'b0);
    check("t4_emit1_last",   m_axis_tlast,  1'b1);
    step(1);
    check("t4_done_sready",  s_axis_tready, 1'b1);
    check("t4_done_vld",     m_axis_tvalid, 1'b0);
    step(2);
    check_counts("t4");

    // T5: clear on the same cycle as a pass increment
    send_frame(2, 16'h88B5, FULL, FULL, 1'b1, 1'b1, w);
    step(1);
    pulse_clear();
    check("t5_passed_clr",  frames_passed,  32'd0);
    check("t5_dropped_clr", frames_dropped, 32'd0);
    send_frame(2, 16'h88B5, FULL, FULL, 1'b1, 1'b1, w);
    step(4);
    check("t5_passed_after", frames_passed, exp_cnt(1));
    check_counts("t5");

    // T6: asynchronous reset while in EMIT0
    m_axis_tready = 1'b0;
    send_frame(2, 16'h88B5, FULL, FULL, 1'b1, 1'b1, w);
    check("t6_pre_vld", m_axis_tvalid, 1'b1);
    #2;
    resetn_stream = 1'b0;
    exp_q.delete();
    model_passed  = 0;
    model_dropped = 0;
    #1;
    check("t6_async_vld",    m_axis_tvalid, 1'b0);
    check("t6_async_sready", s_axis_tready, 1'b1);
    check("t6_async_passed", frames_passed, 32'd0);
    step(1);
    resetn_stream = 1'b1;
    m_axis_tready = 1'b1;
    step(1);
    send_frame(2, 16'h88B5, FULL, MIN42, 1'b1, 1'b1, w);
    step(4);
    check_counts("t6");
    check("t6_passed_lit", frames_passed, exp_cnt(1));

    step(3);
    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
